// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction-fetch unit with a three-state controller.
//
// Parameters:
//   word_size   - instruction width in bits
//   index_size  - program-counter width (2**index_size instructions)
//   halt_opcode - instruction value that stops fetching
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   start         in   begin fetching from start_addr (IDLE/HALTED only)
//   start_addr    in   first fetch address
//   stall         in   hold all fetch state this cycle (FETCH only)
//   branch_en     in   redirect PC to branch_target and flush ir (FETCH only)
//   branch_target in   redirect address
//   ins_val       in   instruction memory data, combinational in prog_count
//   prog_count    out  registered PC driven to instruction memory
//   ir            out  instruction register
//   ir_pc         out  address ir was fetched from
//   ir_valid      out  ir holds a valid, unflushed instruction
//   busy          out  high only while fetching
//   fetch_count   out  instructions captured since reset, saturating at 255
module instr_fetch #(
  parameter int unsigned          word_size   = 8,
  parameter int unsigned          index_size  = 4,
  parameter logic [word_size-1:0] halt_opcode = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [index_size-1:0] start_addr,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic [index_size-1:0] branch_target,
  input  logic [word_size-1:0]  ins_val,
  output logic [index_size-1:0] prog_count,
  output logic [word_size-1:0]  ir,
  output logic [index_size-1:0] ir_pc,
  output logic                  ir_valid,
  output logic                  busy,
  output logic [7:0]            fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } state_e;

  state_e                state_q, state_d;
  logic [index_size-1:0] prog_count_q, prog_count_d;
  logic [word_size-1:0]  ir_q, ir_d;
  logic [index_size-1:0] ir_pc_q, ir_pc_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  busy_q, busy_d;
  logic [7:0]            fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    prog_count_d  = prog_count_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      IDLE, HALTED: begin
        // Outside FETCH only start is honoured; ir stays visible but is
        // marked stale from the first cycle after entry.
        ir_valid_d = 1'b0;
        if (start) begin
          prog_count_d = start_addr;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (branch_en) begin
          prog_count_d = branch_target;
          ir_d         = '0;
          ir_valid_d   = 1'b0;
        end else if (!stall) begin
          ir_d          = ins_val;
          ir_pc_d       = prog_count_q;
          ir_valid_d    = 1'b1;
          fetch_count_d = (fetch_count_q == 8'hFF) ? fetch_count_q
                                                   : fetch_count_q + 8'd1;
          if (ins_val == halt_opcode) begin
            // PC stays on the halt instruction's address.
            state_d = HALTED;
          end else begin
            prog_count_d = prog_count_q + index_size'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // busy is registered from the next state so it tracks state exactly.
    busy_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prog_count_q  <= '0;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      prog_count_q  <= prog_count_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      busy_q        <= busy_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign prog_count  = prog_count_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign busy        = busy_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
// Observed outputs are packed as {prog_count, ir, ir_pc, ir_valid, busy,
// fetch_count} (4+8+4+1+1+8 bits) and compared against hand-computed values.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] start_addr;
  logic       stall;
  logic       branch_en;
  logic [3:0] branch_target;
  logic [7:0] ins_val;
  logic [3:0] prog_count;
  logic [7:0] ir;
  logic [3:0] ir_pc;
  logic       ir_valid;
  logic       busy;
  logic [7:0] fetch_count;

  logic [7:0]  mem [16];
  logic [25:0] snap;
  logic [25:0] exp;
  int          checks;
  int          failures;

  instr_fetch #(
    .word_size  (8),
    .index_size (4),
    .halt_opcode(8'hFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .ins_val      (ins_val),
    .prog_count   (prog_count),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .busy         (busy),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb ins_val = mem[prog_count];
  assign snap = {prog_count, ir, ir_pc, ir_valid, busy, fetch_count};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int unsigned i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; stall = 1'b0; branch_en = 1'b0;
    start_addr = '0; branch_target = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    exp = '0;
    checks++; if (snap !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", snap, exp); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    do_reset();
    start = 1'b1; start_addr = 4'd0;
    tick();
    start = 1'b0;
    exp = {4'd0, 8'h00, 4'd0, 1'b0, 1'b1, 8'd0};
    checks++; if (snap !== exp) begin failures++; $display("FAIL basic_enter got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd1, 8'h10, 4'd0, 1'b1, 1'b1, 8'd1};
    checks++; if (snap !== exp) begin failures++; $display("FAIL basic_cap0 got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd2, 8'h11, 4'd1, 1'b1, 1'b1, 8'd2};
    checks++; if (snap !== exp) begin failures++; $display("FAIL basic_cap1 got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd3, 8'h12, 4'd2, 1'b1, 1'b1, 8'd3};
    checks++; if (snap !== exp) begin failures++; $display("FAIL basic_cap2 got=%h exp=%h", snap, exp); end
  endtask

  task automatic test_wrap();
    do_reset();
    start = 1'b1; start_addr = 4'd14;
    tick();
    start = 1'b0;
    exp = {4'd14, 8'h00, 4'd0, 1'b0, 1'b1, 8'd0};
    checks++; if (snap !== exp) begin failures++; $display("FAIL wrap_enter got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd15, 8'h1E, 4'd14, 1'b1, 1'b1, 8'd1};
    checks++; if (snap !== exp) begin failures++; $display("FAIL wrap_14 got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd0, 8'h1F, 4'd15, 1'b1, 1'b1, 8'd2};
    checks++; if (snap !== exp) begin failures++; $display("FAIL wrap_15 got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd1, 8'h10, 4'd0, 1'b1, 1'b1, 8'd3};
    checks++; if (snap !== exp) begin failures++; $display("FAIL wrap_0 got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd2, 8'h11, 4'd1, 1'b1, 1'b1, 8'd4};
    checks++; if (snap !== exp) begin failures++; $display("FAIL wrap_1 got=%h exp=%h", snap, exp); end
  endtask

  task automatic test_halt();
    do_reset();
    mem[3] = 8'hFF;
    start = 1'b1; start_addr = 4'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    exp = {4'd3, 8'h12, 4'd2, 1'b1, 1'b1, 8'd3};
    checks++; if (snap !== exp) begin failures++; $display("FAIL halt_pre got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd3, 8'hFF, 4'd3, 1'b1, 1'b0, 8'd4};
    checks++; if (snap !== exp) begin failures++; $display("FAIL halt_capture got=%h exp=%h", snap, exp); end
    // stall and branch must be ignored while halted
    stall = 1'b1; branch_en = 1'b1; branch_target = 4'd9;
    tick();
    stall = 1'b0; branch_en = 1'b0;
    exp = {4'd3, 8'hFF, 4'd3, 1'b0, 1'b0, 8'd4};
    checks++; if (snap !== exp) begin failures++; $display("FAIL halt_next got=%h exp=%h", snap, exp); end
    tick();
    checks++; if (snap !== exp) begin failures++; $display("FAIL halt_hold got=%h exp=%h", snap, exp); end
    start = 1'b1; start_addr = 4'd5;
    tick();
    start = 1'b0;
    exp = {4'd5, 8'hFF, 4'd3, 1'b0, 1'b1, 8'd4};
    checks++; if (snap !== exp) begin failures++; $display("FAIL halt_restart got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd6, 8'h15, 4'd5, 1'b1, 1'b1, 8'd5};
    checks++; if (snap !== exp) begin failures++; $display("FAIL halt_resume got=%h exp=%h", snap, exp); end
    mem[3] = 8'h13;
  endtask

  task automatic test_branch_stall();
    do_reset();
    start = 1'b1; start_addr = 4'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    exp = {4'd2, 8'h11, 4'd1, 1'b1, 1'b1, 8'd2};
    checks++; if (snap !== exp) begin failures++; $display("FAIL br_pre got=%h exp=%h", snap, exp); end
    branch_en = 1'b1; branch_target = 4'd9; stall = 1'b1;
    tick();
    branch_en = 1'b0; stall = 1'b0;
    exp = {4'd9, 8'h00, 4'd1, 1'b0, 1'b1, 8'd2};
    checks++; if (snap !== exp) begin failures++; $display("FAIL br_redirect got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd10, 8'h19, 4'd9, 1'b1, 1'b1, 8'd3};
    checks++; if (snap !== exp) begin failures++; $display("FAIL br_capture got=%h exp=%h", snap, exp); end
    stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (snap !== exp) begin failures++; $display("FAIL stall_hold%0d got=%h exp=%h", n, snap, exp); end
    end
    stall = 1'b0;
    tick();
    exp = {4'd11, 8'h1A, 4'd10, 1'b1, 1'b1, 8'd4};
    checks++; if (snap !== exp) begin failures++; $display("FAIL stall_release got=%h exp=%h", snap, exp); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    mem[2] = 8'hFF; mem[8] = 8'hFF;
    start = 1'b1; start_addr = 4'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    // halt opcode presented together with a branch: branch wins
    branch_en = 1'b1; branch_target = 4'd7;
    tick();
    branch_en = 1'b0;
    exp = {4'd7, 8'h00, 4'd1, 1'b0, 1'b1, 8'd2};
    checks++; if (snap !== exp) begin failures++; $display("FAIL sim_branch_halt got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd8, 8'h17, 4'd7, 1'b1, 1'b1, 8'd3};
    checks++; if (snap !== exp) begin failures++; $display("FAIL sim_after_branch got=%h exp=%h", snap, exp); end
    // halt opcode presented under stall: no halt yet
    stall = 1'b1;
    tick();
    stall = 1'b0;
    checks++; if (snap !== exp) begin failures++; $display("FAIL sim_stall_halt got=%h exp=%h", snap, exp); end
    tick();
    exp = {4'd8, 8'hFF, 4'd8, 1'b1, 1'b0, 8'd4};
    checks++; if (snap !== exp) begin failures++; $display("FAIL sim_halt_after_stall got=%h exp=%h", snap, exp); end
    mem[2] = 8'h12; mem[8] = 8'h18;
  endtask

  task automatic test_saturation();
    do_reset();
    start = 1'b1; start_addr = 4'd0;
    tick();
    start = 1'b0;
    repeat (254) tick();
    checks++; if (fetch_count !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", fetch_count); end
    tick();
    checks++; if (fetch_count !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", fetch_count); end
    repeat (5) tick();
    checks++; if (fetch_count !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", fetch_count); end
    checks++; if (prog_count !== 4'd4) begin failures++; $display("FAIL sat_pc got=%0d exp=4", prog_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1; start_addr = 4'd6;
    tick();
    start = 1'b0;
    tick();
    tick();
    exp = {4'd8, 8'h17, 4'd7, 1'b1, 1'b1, 8'd2};
    checks++; if (snap !== exp) begin failures++; $display("FAIL ar_pre got=%h exp=%h", snap, exp); end
    #3;
    rst_n = 1'b0;
    #1;
    exp = '0;
    checks++; if (snap !== exp) begin failures++; $display("FAIL ar_immediate got=%h exp=%h", snap, exp); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (snap !== exp) begin failures++; $display("FAIL ar_stay_idle got=%h exp=%h", snap, exp); end
    start = 1'b1; start_addr = 4'd4;
    tick();
    start = 1'b0;
    exp = {4'd4, 8'h00, 4'd0, 1'b0, 1'b1, 8'd0};
    checks++; if (snap !== exp) begin failures++; $display("FAIL ar_restart got=%h exp=%h", snap, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    start = 1'b0; stall = 1'b0; branch_en = 1'b0;
    start_addr = '0; branch_target = '0;
    checks = 0;
    failures = 0;
    fill_mem();
    test_reset();
    test_basic_fetch();
    test_wrap();
    test_halt();
    test_branch_stall();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter word_size, default 8, instruction width in bits.
REQ-002 SHALL have parameter index_size, default 4, program-counter width (16 instructions).
REQ-003 SHALL have parameter halt_opcode, default 8'hFF, instruction value that stops fetching.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin fetching from start_addr; honoured only in IDLE or HALTED.
REQ-007 SHALL have port start_addr  input  index_size  first fetch address on start.
REQ-008 SHALL have port stall  input  1  hold all fetch state this cycle.
REQ-009 SHALL have port branch_en  input  1  redirect PC to branch_target and flush IR.
REQ-010 SHALL have port branch_target  input  index_size  redirect address.
REQ-011 SHALL have port ins_val  input  word_size  instruction from instruction memory; combinational function of prog_count.
REQ-012 SHALL have port prog_count  output  index_size  registered PC, driven to instruction memory.
REQ-013 SHALL have port ir  output  word_size  instruction register.
REQ-014 SHALL have port ir_pc  output  index_size  address from which ir was fetched.
REQ-015 SHALL have port ir_valid  output  1  ir holds a valid, unflushed instruction.
REQ-016 SHALL have port busy  output  1  high only in state FETCH.
REQ-017 SHALL have port fetch_count  output  8  number of instructions captured since reset, saturating at 255.

Function
REQ-018 SHALL implement states IDLE, FETCH, HALTED; busy = (state == FETCH).
REQ-019 SHALL, in IDLE or HALTED with start=1: load prog_count <= start_addr, set ir_valid <= 0, go to FETCH.
REQ-020 SHALL, in IDLE or HALTED with start=0: hold prog_count, ir, ir_pc; ir_valid <= 0.
REQ-021 SHALL ignore start, stall and branch_en in IDLE and HALTED, except start as in REQ-019.
REQ-022 SHALL, in FETCH, apply priority branch_en > stall > normal fetch.
REQ-023 SHALL, in FETCH with branch_en=1: prog_count <= branch_target, ir <= 0, ir_valid <= 0; fetch_count unchanged; stay in FETCH.
REQ-024 SHALL, in FETCH with stall=1 and branch_en=0: hold prog_count, ir, ir_pc, ir_valid, fetch_count and state.
REQ-025 SHALL, in normal fetch with ins_val != halt_opcode: ir <= ins_val, ir_pc <= prog_count, ir_valid <= 1, prog_count <= prog_count+1.
REQ-026 SHALL wrap prog_count from 2^index_size-1 to 0 (15 -> 0 at default); there is no error on wrap.
REQ-027 SHALL, in normal fetch with ins_val == halt_opcode: ir <= ins_val, ir_pc <= prog_count, ir_valid <= 1, hold prog_count, go to HALTED.
REQ-028 SHALL increment fetch_count by 1 on every capture under REQ-025 or REQ-027, saturating at 255.
REQ-029 SHALL have a latency of one cycle from prog_count = A to ir = mem[A] with ir_valid=1.
REQ-030 SHALL let branch_en in the same cycle as a halt_opcode fetch win: no capture, no halt.
REQ-031 SHALL let stall in the same cycle as a halt_opcode fetch win: no halt until the fetch completes unstalled.
REQ-032 SHALL clear ir_valid in HALTED one cycle after entry, per REQ-020.

Reset
REQ-033 SHALL, on rst_n=0 at any time and regardless of clk: state=IDLE, prog_count=0, ir=0, ir_pc=0, ir_valid=0, busy=0, fetch_count=0.
REQ-034 SHALL, on reset mid-FETCH, abandon the fetch in progress; after rst_n rises, the block stays in IDLE until start.

Verification
REQ-035 SHALL cover basic fetch: mem[i]=8'h10+i, start with start_addr=0 -> ir = 10,11,12,... on consecutive cycles, ir_pc = 0,1,2, ir_valid=1 from the first edge after FETCH entry.
REQ-036 SHALL cover wrap: start_addr=14, no halt in memory -> ir_pc sequence 14,15,0,1; fetch_count increments each cycle.
REQ-037 SHALL cover halt: mem[3]=8'hFF, start at 0 -> ir=FF, ir_pc=3, state HALTED, prog_count=3, busy=0, ir_valid=0 the next cycle; start with start_addr=5 -> resumes at 5.
REQ-038 SHALL cover branch/stall: branch_en=1 with target 9 while stall=1 at prog_count=2 -> prog_count=9, ir=0, ir_valid=0, next capture ir_pc=9; stall alone for 3 cycles -> all outputs constant.
REQ-039 SHALL cover simultaneous events: halt_opcode at prog_count with branch_en=1 -> no HALTED, prog_count=branch_target; fetch_count driven to 255 -> stays 255.
REQ-040 SHALL cover asynchronous reset: assert rst_n=0 mid-FETCH between clock edges -> all outputs at REQ-033 values immediately; start remains required to resume.
